// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared types and constants for the MIPS fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Byte distance between consecutive instructions
    localparam int PC_STEP   = 4;

    // Flush length applied after a jump redirect
    localparam int JMP_FLUSH = 1;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/branch_target_adder.sv
`default_nettype none
// ============================================================================
// Module      : branch_target_adder
// Description : Combinational branch-target adder (base + byte offset),
//               carry out is discarded so the result wraps modulo 2^PC_W.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_target_adder #(
    parameter int PC_W = 32
) (
    input  logic [PC_W-1:0] i_base,
    input  logic [PC_W-1:0] i_offset,
    output logic [PC_W-1:0] o_sum
);

    // Wrapping add; the offset is already sign-extended to full width
    assign o_sum = i_base + i_offset;

endmodule : branch_target_adder
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Fetch-stage PC controller. Selects the next PC from the
//               sequential, branch-target and jump-target sources, issues
//               flushes on redirects and counts redirects (saturating).
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import mips_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              BR_FLUSH = 2,
    parameter int              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_i,
    input  logic             branch_i,
    input  logic             branch_taken_i,
    input  logic [PC_W-1:0]  branch_pc_i,
    input  logic [PC_W-1:0]  branch_imm_i,
    input  logic             jump_i,
    input  logic [PC_W-1:0]  jump_target_i,
    output logic [PC_W-1:0]  pc_o,
    output logic             fetch_valid_o,
    output logic             flush_o,
    output logic             redirect_o,
    output logic [CNT_W-1:0] redirect_cnt_o
);

    // Flush counter load values: the counter holds "cycles left minus one"
    localparam logic [1:0]      c_br_flush_load  = 2'(BR_FLUSH - 1);
    localparam logic [1:0]      c_jmp_flush_load = 2'(JMP_FLUSH - 1);
    localparam logic [PC_W-1:0] c_pc_step        = PC_W'(PC_STEP);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PC_W-1:0]  r_pc;
    logic [PC_W-1:0]  w_pc_nxt;
    logic [PC_W-1:0]  w_pc_seq;
    logic [PC_W-1:0]  w_branch_target;
    logic [1:0]       r_flush_cnt;
    logic [1:0]       w_flush_cnt_nxt;
    logic             r_redirect;
    logic             w_redirect_nxt;
    logic [CNT_W-1:0] r_redirect_cnt;
    logic [CNT_W-1:0] w_redirect_cnt_nxt;
    logic             w_take_branch;

    branch_target_adder #(
        .PC_W     (PC_W)
    ) u_branch_target_adder (
        .i_base   (branch_pc_i),
        .i_offset (branch_imm_i),
        .o_sum    (w_branch_target)
    );

    assign w_pc_seq      = r_pc + c_pc_step;
    assign w_take_branch = branch_i & branch_taken_i;

    // State, PC and statistics registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= BOOT;
            r_pc           <= RESET_PC;
            r_flush_cnt    <= 2'd0;
            r_redirect     <= 1'b0;
            r_redirect_cnt <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_pc           <= w_pc_nxt;
            r_flush_cnt    <= w_flush_cnt_nxt;
            r_redirect     <= w_redirect_nxt;
            r_redirect_cnt <= w_redirect_cnt_nxt;
        end
    end

    // Next-state / next-PC selection; in FLUSH all requests are from
    // squashed instructions and are ignored
    always_comb begin
        w_state_nxt        = r_state;
        w_pc_nxt           = r_pc;
        w_flush_cnt_nxt    = r_flush_cnt;
        w_redirect_nxt     = 1'b0;
        w_redirect_cnt_nxt = r_redirect_cnt;

        case (r_state)
            BOOT: begin
                w_state_nxt = RUN;
            end
            RUN: begin
                if (w_take_branch) begin
                    // Branch is older than a concurrent jump, so it wins
                    w_pc_nxt        = w_branch_target;
                    w_state_nxt     = FLUSH;
                    w_flush_cnt_nxt = c_br_flush_load;
                    w_redirect_nxt  = 1'b1;
                end else if (jump_i) begin
                    w_pc_nxt        = jump_target_i;
                    w_state_nxt     = FLUSH;
                    w_flush_cnt_nxt = c_jmp_flush_load;
                    w_redirect_nxt  = 1'b1;
                end else if (!stall_i) begin
                    w_pc_nxt = w_pc_seq;
                end
            end
            FLUSH: begin
                w_pc_nxt = w_pc_seq;
                if (r_flush_cnt == 2'd0) begin
                    w_state_nxt = RUN;
                end else begin
                    w_flush_cnt_nxt = r_flush_cnt - 2'd1;
                end
            end
            default: begin
                w_state_nxt = BOOT;
            end
        endcase

        if (w_redirect_nxt && (r_redirect_cnt != {CNT_W{1'b1}})) begin
            w_redirect_cnt_nxt = r_redirect_cnt + 1'b1;
        end
    end

    assign pc_o           = r_pc;
    assign fetch_valid_o  = (r_state != BOOT);
    assign flush_o        = (r_state == FLUSH);
    assign redirect_o     = r_redirect;
    assign redirect_cnt_o = r_redirect_cnt;

endmodule : pc_sequencer
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Scoreboard testbench for pc_sequencer with a behavioural
//               reference model, directed scenarios and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    localparam int          PC_W     = 32;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam int          BR_FLUSH = 2;
    localparam int          CNT_W    = 2;
    localparam int          CNT_MAX  = (1 << CNT_W) - 1;

    typedef struct {
        logic [31:0] pc;
        logic        fv;
        logic        flush;
        logic        redir;
        logic [31:0] cnt;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             stall_i;
    logic             branch_i;
    logic             branch_taken_i;
    logic [PC_W-1:0]  branch_pc_i;
    logic [PC_W-1:0]  branch_imm_i;
    logic             jump_i;
    logic [PC_W-1:0]  jump_target_i;
    logic [PC_W-1:0]  pc_o;
    logic             fetch_valid_o;
    logic             flush_o;
    logic             redirect_o;
    logic [CNT_W-1:0] redirect_cnt_o;

    exp_t sb[$];
    int   n_pass;
    int   n_total;

    // Reference model: what the outputs currently show
    logic        m_boot;
    logic [31:0] m_pc;
    int          m_flush_left;
    logic        m_redir;
    int          m_cnt;

    pc_sequencer #(
        .PC_W           (PC_W),
        .RESET_PC       (RESET_PC),
        .BR_FLUSH       (BR_FLUSH),
        .CNT_W          (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_i        (stall_i),
        .branch_i       (branch_i),
        .branch_taken_i (branch_taken_i),
        .branch_pc_i    (branch_pc_i),
        .branch_imm_i   (branch_imm_i),
        .jump_i         (jump_i),
        .jump_target_i  (jump_target_i),
        .pc_o           (pc_o),
        .fetch_valid_o  (fetch_valid_o),
        .flush_o        (flush_o),
        .redirect_o     (redirect_o),
        .redirect_cnt_o (redirect_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_boot       = 1'b1;
        m_pc         = RESET_PC;
        m_flush_left = 0;
        m_redir      = 1'b0;
        m_cnt        = 0;
    endtask

    task automatic model_redirect(input logic [31:0] target, input int len);
        m_pc         = target;
        m_flush_left = len;
        m_redir      = 1'b1;
        if (m_cnt < CNT_MAX) m_cnt++;
    endtask

    // One clock of the fetch-stage rules, applied to the sampled request
    task automatic model_step(input bit st, input bit br, input bit tk,
                              input logic [31:0] bpc, input logic [31:0] imm,
                              input bit jp, input logic [31:0] jt);
        m_redir = 1'b0;
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_flush_left > 0) begin
            m_pc = m_pc + 32'd4;
            m_flush_left--;
        end else if (br && tk) begin
            model_redirect(bpc + imm, BR_FLUSH);
        end else if (jp) begin
            model_redirect(jt, 1);
        end else if (!st) begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.pc    = m_pc;
        e.fv    = !m_boot;
        e.flush = (m_flush_left > 0);
        e.redir = m_redir;
        e.cnt   = 32'(m_cnt);
        return e;
    endfunction

    // Applies one cycle of requests (called between edges), records the
    // expected response and advances to the next falling edge
    task automatic drive(input bit st, input bit br, input bit tk,
                         input logic [31:0] bpc, input logic [31:0] imm,
                         input bit jp, input logic [31:0] jt);
        stall_i        = st;
        branch_i       = br;
        branch_taken_i = tk;
        branch_pc_i    = bpc;
        branch_imm_i   = imm;
        jump_i         = jp;
        jump_target_i  = jt;
        model_step(st, br, tk, bpc, imm, jp, jt);
        sb.push_back(model_out());
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    endtask

    task automatic chk_now(input string tag);
        exp_t e;
        e = model_out();
        chk({tag, "_pc"},    pc_o, e.pc);
        chk({tag, "_fv"},    32'(fetch_valid_o), 32'(e.fv));
        chk({tag, "_flush"}, 32'(flush_o), 32'(e.flush));
        chk({tag, "_redir"}, 32'(redirect_o), 32'(e.redir));
        chk({tag, "_cnt"},   32'(redirect_cnt_o), e.cnt);
    endtask

    // Monitor: the DUT presents a fetch every cycle; compare after each edge
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("pc",       pc_o, e.pc);
            chk("fetch_vld", 32'(fetch_valid_o), 32'(e.fv));
            chk("flush",    32'(flush_o), 32'(e.flush));
            chk("redirect", 32'(redirect_o), 32'(e.redir));
            chk("rd_cnt",   32'(redirect_cnt_o), e.cnt);
        end
    end

    initial begin
        n_pass         = 0;
        n_total        = 0;
        rst_n          = 1'b0;
        stall_i        = 1'b0;
        branch_i       = 1'b0;
        branch_taken_i = 1'b0;
        branch_pc_i    = '0;
        branch_imm_i   = '0;
        jump_i         = 1'b0;
        jump_target_i  = '0;
        model_reset();

        #2;
        chk_now("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_now("boot");

        // Reset and run
        idle(4);
        // Taken branch with negative offset
        drive(0, 1, 1, 32'h100, 32'hFFFF_FFF0, 0, 32'h0);
        idle(4);
        // Branch + jump + stall together, then a jump during FLUSH
        drive(1, 1, 1, 32'h1F0, 32'h10, 1, 32'h400);
        drive(0, 0, 0, 32'h0, 32'h0, 1, 32'h800);
        idle(3);
        // Stall at 0x40, then a not-taken branch
        drive(0, 0, 0, 32'h0, 32'h0, 1, 32'h3C);
        idle(1);
        for (int k = 0; k < 3; k++) drive(1, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        drive(0, 1, 0, 32'h40, 32'h100, 0, 32'h0);
        idle(2);
        // Sequential wrap past the top of the address space
        drive(0, 0, 0, 32'h0, 32'h0, 1, 32'hFFFF_FFF8);
        idle(3);
        // Redirect counter saturation
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 0, 32'h0, 32'h0, 1, 32'h1000 + 32'(k * 16));
            idle(1);
        end

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            logic [31:0] imm;
            imm = ($urandom_range(0, 1) == 0) ? (($urandom & 32'h3FC) - 32'h200) : ($urandom & ~32'h3);
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 7) == 0) ? (32'hFFFF_FF00 | ($urandom & 32'hFC)) : ($urandom & ~32'h3),
                  imm, $urandom_range(0, 5) == 0, $urandom & ~32'h3);
        end

        // Asynchronous reset in the middle of the first FLUSH cycle
        drive(0, 1, 1, 32'h2000, 32'h40, 0, 32'h0);
        chk("pre_rst_flush", 32'(flush_o), 32'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_now("async_rst");
        stall_i  = 1'b1;
        jump_i   = 1'b1;
        branch_i = 1'b1;
        branch_taken_i = 1'b1;
        repeat (2) @(negedge clk);
        chk_now("rst_hold");
        rst_n = 1'b1;
        #1;
        chk_now("reboot");
        idle(3);
        drive(0, 0, 0, 32'h0, 32'h0, 1, 32'h500);
        idle(3);

        // Let the monitor drain the remaining expectations
        for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_pc_sequencer
`default_nettype wire
